ascon_ctrl_fsm: RTL
===================

Name: ascon_ctrl_fsm

Overview:
- Top-level sequencing FSM for the ASCON core; it selects the mode, drives the round/absorb counter and the permutation datapath.
- It handshakes AD, text and output words with the host interface, and tells the datapath when to XOR the key, add domain separation and emit the tag or digest.
- It sits between the bus/host wrapper and the counter and permutation datapath.

Parameters:
- HASH_SQZ_WORDS, 4, number of 64-bit digest words squeezed in hash mode (256-bit digest).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle job start; ignored unless state is IDLE
- mode_i  in  2  ascon_mode_t, sampled on an accepted start
- no_ad_i  in  1  empty AD, sampled on an accepted start
- ad_valid_i / ad_last_i  in  1/1  AD or hash-message word valid; last word of the stream
- text_valid_i / text_last_i  in  1/1  plaintext/ciphertext word valid; last word of the stream
- out_ready_i  in  1  sink ready for an output word
- pdone_i  in  1  counter: permutation finishes this cycle
- abs_cnt_i  in  2  counter: word index within the current rate block
- init_o  out  1  pulse: load ROUNDS_A and start the initialisation permutation
- perm_en_o  out  1  permutation round enable
- abs_ad_do_o, abs_text_do_o  out  1  word absorbed this cycle
- eot_add_key_o  out  1  final key XOR plus load ROUNDS_A
- sqz_hash_do_o  out  1  start the next hash squeeze permutation
- key_xor_o, dsep_o  out  1  post-init key XOR; domain-separation bit
- hash_flag_o, ascon_a_o  out  1  registered mode decode
- ad_ready_o, text_ready_o, out_valid_o  out  1  handshakes
- out_sel_o  out  2  out_sel_t: CT / TAG / HASH
- busy_o, done_o, proto_err_o  out  1  status

Behaviour:
- All outputs reset to 0; state resets to IDLE. Asynchronous reset mid-job returns to IDLE with no further pulses.
- States: IDLE, INIT_PERM, KEY_XOR, ABS_AD, AD_PERM, DSEP, ABS_TEXT, TEXT_PERM, FINAL_PERM, TAG_OUT, SQZ_OUT, SQZ_PERM, DONE.
- IDLE:
  - start_i=1 → latch mode, no_ad, hash_flag_o and ascon_a_o.
  - Same cycle: init_o=1 and busy_o=1; next state INIT_PERM.
- Permutation states (INIT/AD/TEXT/FINAL/SQZ_PERM):
  - perm_en_o=1 every cycle.
  - Leave on the cycle pdone_i=1; the next state is entered on the following clock.
- INIT_PERM exit:
  - hash mode → ABS_AD.
  - AEAD mode → KEY_XOR (key_xor_o=1 for one cycle), then ABS_AD if no_ad=0, else DSEP.
- Block boundaries:
  - last_word = (abs_cnt_i == (ascon_a_o ? 1 : 0)).
  - 128a: 2 words per block; 128 and hash: 1 word per block.
- ABS_AD:
  - ad_ready_o=1; each ad_valid_i handshake gives abs_ad_do_o=1.
  - On last_word → AD_PERM.
  - After AD_PERM: if ad_last was seen, hash → SQZ_OUT and AEAD → DSEP; otherwise → ABS_AD.
- DSEP: dsep_o=1 for one cycle → ABS_TEXT.
- ABS_TEXT:
  - text_ready_o = out_ready_i; out_valid_o = text_valid_i; out_sel_o = CT.
  - Each handshake (text_valid_i & out_ready_i) gives abs_text_do_o=1.
  - On last_word with text_last_i=0 → TEXT_PERM → ABS_TEXT.
  - On last_word with text_last_i=1: abs_text_do_o and eot_add_key_o in the same cycle (counter gives ROUNDS_A priority) → FINAL_PERM.
- FINAL_PERM → TAG_OUT:
  - out_valid_o=1, out_sel_o=TAG.
  - out_ready_i → DONE.
- SQZ_OUT:
  - out_valid_o=1, out_sel_o=HASH.
  - On handshake: if sqz_cnt < HASH_SQZ_WORDS-1, sqz_hash_do_o=1 and sqz_cnt++ → SQZ_PERM → SQZ_OUT.
  - Otherwise → DONE. sqz_cnt is 3 bits and clears on entry from AD_PERM.
- DONE: done_o=1 for one cycle, busy_o=0 → IDLE.
- Full padded blocks only:
  - ad_last_i or text_last_i on a non-last word sets proto_err_o.
  - That last flag is ignored and the job continues.
  - proto_err_o is sticky until the next accepted start.
- start_i while busy: ignored, no effect.
- No dropped handshakes: valid without ready holds state.
- Exactly one of abs_ad_do_o / abs_text_do_o / init_o / sqz_hash_do_o may be high per cycle. eot_add_key_o with abs_text_do_o is the only overlap.

Decomposition:
- Shared package ascon_cfg holds:
  - ascon_mode_t: ASCON_128=0, ASCON_128A=1, ASCON_HASH=2.
  - out_sel_t.
  - ctrl_state_t.
  - ROUNDS_A=12, ROUNDS_B0=6, ROUNDS_B1=8.
- No sub-module; the squeeze counter lives inline. The bench instantiates this FSM together with the existing round counter.

Test Plan:
- ASCON_128, 1 AD word, 1 text word with last:
  - 12 perm_en cycles, key_xor, 6 perm_en, dsep, then eot_add_key with abs_text_do in the same cycle.
  - 12 perm_en, TAG beat, done_o.
- ASCON_128A, no_ad=1, 4 text words (2 blocks):
  - key_xor directly followed by dsep.
  - 8-cycle TEXT_PERM after word 2; eot_add_key on word 4; tag emitted.
- ASCON_HASH, 1 message word with last:
  - init, 12-round perm after absorb.
  - 4 HASH out beats, 3 sqz_hash_do pulses each followed by 12 perm_en, then done_o.
- Backpressure:
  - out_ready_i=0 for 5 cycles in ABS_TEXT → no abs_text_do_o and state held.
  - Resumes exactly one absorb per handshake.
- ASCON_128A with text_last_i on word 1 of a block → proto_err_o=1; the job continues to word 2. A new start_i clears proto_err_o.
- rst_n_i asserted during FINAL_PERM → all outputs 0 immediately. A subsequent start_i starts a clean job.

Source files
------------

// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared ASCON control types: modes, output select, FSM states.
// Round counts used by the round counter alongside this FSM.
package ascon_cfg;

  typedef enum logic [1:0] {
    ASCON_128  = 2'd0,
    ASCON_128A = 2'd1,
    ASCON_HASH = 2'd2
  } ascon_mode_t;

  typedef enum logic [1:0] {
    OUT_CT   = 2'd0,
    OUT_TAG  = 2'd1,
    OUT_HASH = 2'd2
  } out_sel_t;

  typedef logic [3:0] ctrl_state_t;

  localparam ctrl_state_t ST_IDLE       = 4'd0;
  localparam ctrl_state_t ST_INIT_PERM  = 4'd1;
  localparam ctrl_state_t ST_KEY_XOR    = 4'd2;
  localparam ctrl_state_t ST_ABS_AD     = 4'd3;
  localparam ctrl_state_t ST_AD_PERM    = 4'd4;
  localparam ctrl_state_t ST_DSEP       = 4'd5;
  localparam ctrl_state_t ST_ABS_TEXT   = 4'd6;
  localparam ctrl_state_t ST_TEXT_PERM  = 4'd7;
  localparam ctrl_state_t ST_FINAL_PERM = 4'd8;
  localparam ctrl_state_t ST_TAG_OUT    = 4'd9;
  localparam ctrl_state_t ST_SQZ_OUT    = 4'd10;
  localparam ctrl_state_t ST_SQZ_PERM   = 4'd11;
  localparam ctrl_state_t ST_DONE       = 4'd12;

  localparam int unsigned ROUNDS_A  = 12;
  localparam int unsigned ROUNDS_B0 = 6;
  localparam int unsigned ROUNDS_B1 = 8;

endpackage

// File: rtl/ascon_ctrl_fsm.sv
// ASCON top-level sequencer: init, AD/text absorb, tag and hash squeeze.
// Strobes the round counter and permutation datapath; handshakes with host.
module ascon_ctrl_fsm
  import ascon_cfg::*;
#(
  parameter int unsigned HASH_SQZ_WORDS = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  logic       no_ad_i,
  input  logic       ad_valid_i,
  input  logic       ad_last_i,
  input  logic       text_valid_i,
  input  logic       text_last_i,
  input  logic       out_ready_i,
  input  logic       pdone_i,
  input  logic [1:0] abs_cnt_i,
  output logic       init_o,
  output logic       perm_en_o,
  output logic       abs_ad_do_o,
  output logic       abs_text_do_o,
  output logic       eot_add_key_o,
  output logic       sqz_hash_do_o,
  output logic       key_xor_o,
  output logic       dsep_o,
  output logic       hash_flag_o,
  output logic       ascon_a_o,
  output logic       ad_ready_o,
  output logic       text_ready_o,
  output logic       out_valid_o,
  output out_sel_t   out_sel_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       proto_err_o
);

  localparam logic [2:0] SQZ_LAST = 3'(HASH_SQZ_WORDS - 1);

  ctrl_state_t state_q, state_d;
  logic        no_ad_q, no_ad_d;
  logic        hash_q, hash_d;
  logic        a_q, a_d;
  logic        ad_seen_q, ad_seen_d;
  logic        perr_q, perr_d;
  logic [2:0]  sqz_q, sqz_d;
  logic        last_word;

  // 128a packs two words per rate block, the others one
  assign last_word   = abs_cnt_i == (a_q ? 2'd1 : 2'd0);
  assign hash_flag_o = hash_q;
  assign ascon_a_o   = a_q;
  assign proto_err_o = perr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      no_ad_q   <= 1'b0;
      hash_q    <= 1'b0;
      a_q       <= 1'b0;
      ad_seen_q <= 1'b0;
      perr_q    <= 1'b0;
      sqz_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      no_ad_q   <= no_ad_d;
      hash_q    <= hash_d;
      a_q       <= a_d;
      ad_seen_q <= ad_seen_d;
      perr_q    <= perr_d;
      sqz_q     <= sqz_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    no_ad_d       = no_ad_q;
    hash_d        = hash_q;
    a_d           = a_q;
    ad_seen_d     = ad_seen_q;
    perr_d        = perr_q;
    sqz_d         = sqz_q;
    init_o        = 1'b0;
    perm_en_o     = 1'b0;
    abs_ad_do_o   = 1'b0;
    abs_text_do_o = 1'b0;
    eot_add_key_o = 1'b0;
    sqz_hash_do_o = 1'b0;
    key_xor_o     = 1'b0;
    dsep_o        = 1'b0;
    ad_ready_o    = 1'b0;
    text_ready_o  = 1'b0;
    out_valid_o   = 1'b0;
    out_sel_o     = OUT_CT;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_o = start_i;
        if (start_i) begin
          init_o    = 1'b1;
          no_ad_d   = no_ad_i;
          hash_d    = mode_i == ASCON_HASH;
          a_d       = mode_i == ASCON_128A;
          ad_seen_d = 1'b0;
          perr_d    = 1'b0;
          sqz_d     = 3'd0;
          state_d   = ST_INIT_PERM;
        end
      end
      ST_INIT_PERM: begin
        perm_en_o = 1'b1;
        if (pdone_i) state_d = hash_q ? ST_ABS_AD : ST_KEY_XOR;
      end
      ST_KEY_XOR: begin
        key_xor_o = 1'b1;
        state_d   = no_ad_q ? ST_DSEP : ST_ABS_AD;
      end
      ST_ABS_AD: begin
        ad_ready_o = 1'b1;
        if (ad_valid_i) begin
          abs_ad_do_o = 1'b1;
          if (ad_last_i && !last_word) perr_d = 1'b1;
          if (last_word) begin
            ad_seen_d = ad_last_i;
            state_d   = ST_AD_PERM;
          end
        end
      end
      ST_AD_PERM: begin
        perm_en_o = 1'b1;
        if (pdone_i) begin
          if (!ad_seen_q) begin
            state_d = ST_ABS_AD;
          end else if (hash_q) begin
            sqz_d   = 3'd0;
            state_d = ST_SQZ_OUT;
          end else begin
            state_d = ST_DSEP;
          end
        end
      end
      ST_DSEP: begin
        dsep_o  = 1'b1;
        state_d = ST_ABS_TEXT;
      end
      ST_ABS_TEXT: begin
        text_ready_o = out_ready_i;
        out_valid_o  = text_valid_i;
        out_sel_o    = OUT_CT;
        if (text_valid_i && out_ready_i) begin
          abs_text_do_o = 1'b1;
          if (text_last_i && !last_word) perr_d = 1'b1;
          if (last_word) begin
            if (text_last_i) begin
              eot_add_key_o = 1'b1;
              state_d       = ST_FINAL_PERM;
            end else begin
              state_d = ST_TEXT_PERM;
            end
          end
        end
      end
      ST_TEXT_PERM: begin
        perm_en_o = 1'b1;
        if (pdone_i) state_d = ST_ABS_TEXT;
      end
      ST_FINAL_PERM: begin
        perm_en_o = 1'b1;
        if (pdone_i) state_d = ST_TAG_OUT;
      end
      ST_TAG_OUT: begin
        out_valid_o = 1'b1;
        out_sel_o   = OUT_TAG;
        if (out_ready_i) state_d = ST_DONE;
      end
      ST_SQZ_OUT: begin
        out_valid_o = 1'b1;
        out_sel_o   = OUT_HASH;
        if (out_ready_i) begin
          if (sqz_q < SQZ_LAST) begin
            sqz_hash_do_o = 1'b1;
            sqz_d         = sqz_q + 3'd1;
            state_d       = ST_SQZ_PERM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SQZ_PERM: begin
        perm_en_o = 1'b1;
        if (pdone_i) state_d = ST_SQZ_OUT;
      end
      ST_DONE: begin
        busy_o  = 1'b0;
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
